// File: rtl/conv_win_if.sv
// rtl/conv_win_if.sv - memory, MAC and result-buffer signals of the convolution window sequencer
interface conv_win_if #(
  parameter int DATA_W = 8,
  parameter int RES_W  = 25,
  parameter int ADDR_W = 16
);
  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   rd_en;
  logic [ADDR_W-1:0]      rd_addr;
  logic [DATA_W-1:0]      rd_data;
  logic [16*DATA_W-1:0]   win_data;
  logic                   win_valid;
  logic [RES_W-1:0]       mac_result;
  logic                   wr_en;
  logic [ADDR_W-1:0]      wr_addr;
  logic [RES_W-1:0]       wr_data;

  modport master (
    input  start, rd_data, mac_result,
    output busy, done, rd_en, rd_addr, win_data, win_valid, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, rd_data, mac_result,
    input  busy, done, rd_en, rd_addr, win_data, win_valid, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/conv_win_ctrl.sv
// rtl/conv_win_ctrl.sv - 4x4 stride-1 window sequencer with column reuse feeding the MAC
module conv_win_ctrl #(
  parameter int DATA_W  = 8,
  parameter int RES_W   = 25,
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int ADDR_W  = 16,
  parameter int MAC_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  conv_win_if.master bus
);
  localparam logic [ADDR_W-1:0] OX_MAX = ADDR_W'(IMG_W - 4);
  localparam logic [ADDR_W-1:0] OY_MAX = ADDR_W'(IMG_H - 4);
  localparam logic [ADDR_W-1:0] OUT_W  = ADDR_W'(IMG_W - 3);
  localparam logic [ADDR_W-1:0] IMG_WA = ADDR_W'(IMG_W);
  localparam logic [15:0]       LAST_WAIT = 16'(MAC_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     ox_q, ox_d;
  logic [ADDR_W-1:0]     oy_q, oy_d;
  logic                  full_q, full_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [16*DATA_W-1:0]  win_q, win_d;
  logic [3*DATA_W-1:0]   col_q, col_d;

  logic [15:0]           fetch_len;
  logic [15:0]           cap_idx;
  logic [4*DATA_W-1:0]   new_col;
  logic [ADDR_W-1:0]     rd_row;
  logic [ADDR_W-1:0]     rd_col;
  logic                  rd_phase;

  assign fetch_len = full_q ? 16'd16 : 16'd4;
  assign cap_idx   = cnt_q - 16'd1;
  assign new_col   = {bus.rd_data, col_q};
  assign rd_phase  = (state_q == S_FETCH) && (cnt_q < fetch_len);
  assign rd_row    = {{(ADDR_W-2){1'b0}}, cnt_q[1:0]};
  // At row start the four columns come from ox..ox+3; afterwards only the new right column.
  assign rd_col    = full_q ? (ox_q + {{(ADDR_W-2){1'b0}}, cnt_q[3:2]}) : (ox_q + ADDR_W'(3));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ox_q    <= '0;
      oy_q    <= '0;
      full_q  <= 1'b0;
      cnt_q   <= '0;
      win_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      full_q  <= full_d;
      cnt_q   <= cnt_d;
      win_q   <= win_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    full_d  = full_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FETCH;
          ox_d    = '0;
          oy_d    = '0;
          full_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_FETCH: begin
        // Read data lags rd_en by one cycle, so cnt-1 names the row being captured.
        if (cnt_q != 16'd0) begin
          case (cap_idx[1:0])
            2'd0: col_d[0*DATA_W +: DATA_W] = bus.rd_data;
            2'd1: col_d[1*DATA_W +: DATA_W] = bus.rd_data;
            2'd2: col_d[2*DATA_W +: DATA_W] = bus.rd_data;
            default: begin
              for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 3; c++) begin
                  win_d[(r*4+c)*DATA_W +: DATA_W] = win_q[(r*4+c+1)*DATA_W +: DATA_W];
                end
                win_d[(r*4+3)*DATA_W +: DATA_W] = new_col[r*DATA_W +: DATA_W];
              end
            end
          endcase
        end
        if (cnt_q == fetch_len) begin
          state_d = S_ISSUE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (cnt_q == LAST_WAIT) begin
          state_d = S_WRITE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WRITE: begin
        cnt_d = '0;
        if (ox_q < OX_MAX) begin
          ox_d    = ox_q + ADDR_W'(1);
          full_d  = 1'b0;
          state_d = S_FETCH;
        end else if (oy_q < OY_MAX) begin
          ox_d    = '0;
          oy_d    = oy_q + ADDR_W'(1);
          full_d  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy      = (state_q == S_FETCH) || (state_q == S_ISSUE) ||
                         (state_q == S_WAIT)  || (state_q == S_WRITE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.rd_en     = rd_phase;
  assign bus.rd_addr   = rd_phase ? ((oy_q + rd_row) * IMG_WA + rd_col) : '0;
  assign bus.win_data  = win_q;
  assign bus.win_valid = (state_q == S_ISSUE);
  assign bus.wr_en     = (state_q == S_WRITE);
  assign bus.wr_addr   = (state_q == S_WRITE) ? (oy_q * OUT_W + ox_q) : '0;
  assign bus.wr_data   = (state_q == S_WRITE) ? bus.mac_result : '0;
endmodule

// File: tb/tb_conv_win_ctrl.sv
// tb/tb_conv_win_ctrl.sv - directed vector bench: 4x4 frame, 6x5 frames at MAC latency 1 and 3
module tb_conv_win_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] st = 3'b000;
  logic neg = 1'b0;
  int cyc = 0;
  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_win_if #(.DATA_W(8), .RES_W(25), .ADDR_W(16)) i0 ();
  conv_win_if #(.DATA_W(8), .RES_W(25), .ADDR_W(16)) i1 ();
  conv_win_if #(.DATA_W(8), .RES_W(25), .ADDR_W(16)) i2 ();

  conv_win_ctrl #(.IMG_W(4), .IMG_H(4), .MAC_LAT(1)) u0 (.clk(clk), .rst(rst), .bus(i0.master));
  conv_win_ctrl #(.IMG_W(6), .IMG_H(5), .MAC_LAT(1)) u1 (.clk(clk), .rst(rst), .bus(i1.master));
  conv_win_ctrl #(.IMG_W(6), .IMG_H(5), .MAC_LAT(3)) u2 (.clk(clk), .rst(rst), .bus(i2.master));

  assign i0.start = st[0];
  assign i1.start = st[1];
  assign i2.start = st[2];

  function automatic logic [7:0] pix(input logic [15:0] a);
    return neg ? 8'hFF : a[7:0];
  endfunction

  function automatic logic [24:0] mac_f(input logic [127:0] w);
    int s;
    s = 0;
    for (int k = 0; k < 16; k++) s += int'($signed(w[k*8 +: 8]));
    if (s < 0) s = 0;
    return 25'(s);
  endfunction

  // Feature-map memory with one-cycle read latency and a ReLU sum MAC per instance
  logic [24:0] m0, m1, m2a, m2b, m2c;
  always @(posedge clk) begin
    if (i0.rd_en) i0.rd_data <= pix(i0.rd_addr);
    if (i1.rd_en) i1.rd_data <= pix(i1.rd_addr);
    if (i2.rd_en) i2.rd_data <= pix(i2.rd_addr);
    m0  <= mac_f(i0.win_data);
    m1  <= mac_f(i1.win_data);
    m2a <= mac_f(i2.win_data);
    m2b <= m2a;
    m2c <= m2b;
  end
  assign i0.mac_result = m0;
  assign i1.mac_result = m1;
  assign i2.mac_result = m2c;

  int nw[3], nd[3], nr[3], nv[3];
  int wa[3][32], wd[3][32], wc[3][32];
  int rl[16];
  logic [127:0] win0;

  always @(negedge clk) begin
    if (i0.wr_en && nw[0] < 32) begin wa[0][nw[0]] = int'(i0.wr_addr); wd[0][nw[0]] = int'(i0.wr_data); wc[0][nw[0]] = cyc; nw[0]++; end
    if (i1.wr_en && nw[1] < 32) begin wa[1][nw[1]] = int'(i1.wr_addr); wd[1][nw[1]] = int'(i1.wr_data); wc[1][nw[1]] = cyc; nw[1]++; end
    if (i2.wr_en && nw[2] < 32) begin wa[2][nw[2]] = int'(i2.wr_addr); wd[2][nw[2]] = int'(i2.wr_data); wc[2][nw[2]] = cyc; nw[2]++; end
    if (i0.rd_en) begin if (nr[0] < 16) rl[nr[0]] = int'(i0.rd_addr); nr[0]++; end
    if (i1.rd_en) nr[1]++;
    if (i2.rd_en) nr[2]++;
    if (i0.win_valid) begin if (nv[0] == 0) win0 = i0.win_data; nv[0]++; end
    if (i1.win_valid) nv[1]++;
    if (i2.win_valid) nv[2]++;
    if (i0.done) nd[0]++;
    if (i1.done) nd[1]++;
    if (i2.done) nd[2]++;
  end

  typedef struct {
    int run;
    int inst;
    int idx;
    int addr;
    int data;
    int gap;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    for (int i = 0; i < 3; i++) begin
      nw[i] = 0; nd[i] = 0; nr[i] = 0; nv[i] = 0;
    end
  endtask

  task automatic pulse(input int i);
    st[i] = 1'b1;
    @(posedge clk); #1;
    st[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int lim);
    int n;
    n = 0;
    while (nd[i] == 0 && n < lim) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("done_seen", nd[i], 1);
  endtask

  task automatic apply_vecs(input int run);
    foreach (vecs[k]) begin
      if (vecs[k].run == run) begin
        chk($sformatf("r%0d_wr_addr[%0d]", run, vecs[k].idx), wa[vecs[k].inst][vecs[k].idx], vecs[k].addr);
        chk($sformatf("r%0d_wr_data[%0d]", run, vecs[k].idx), wd[vecs[k].inst][vecs[k].idx], vecs[k].data);
        if (vecs[k].gap >= 0)
          chk($sformatf("r%0d_gap[%0d]", run, vecs[k].idx),
              wc[vecs[k].inst][vecs[k].idx] - wc[vecs[k].inst][vecs[k].idx-1], vecs[k].gap);
      end
    end
  endtask

  initial begin
    int rd_before;
    // Window sum for 6-wide map at (ox,oy): 16*(6*oy+ox) + 168
    vecs.push_back('{0, 0, 0, 0, 120, -1});
    vecs.push_back('{1, 1, 0, 0, 168, -1});
    vecs.push_back('{1, 1, 1, 1, 184, 8});
    vecs.push_back('{1, 1, 2, 2, 200, 8});
    vecs.push_back('{1, 1, 3, 3, 264, 20});
    vecs.push_back('{1, 1, 4, 4, 280, 8});
    vecs.push_back('{1, 1, 5, 5, 296, 8});
    vecs.push_back('{2, 2, 0, 0, 168, -1});
    vecs.push_back('{2, 2, 1, 1, 184, 10});
    vecs.push_back('{2, 2, 2, 2, 200, 10});
    vecs.push_back('{2, 2, 3, 3, 264, 22});
    vecs.push_back('{2, 2, 4, 4, 280, 10});
    vecs.push_back('{2, 2, 5, 5, 296, 10});
    for (int k = 0; k < 6; k++) vecs.push_back('{3, 1, k, k, 0, -1});
    vecs.push_back('{4, 1, 0, 0, 168, -1});
    vecs.push_back('{4, 1, 3, 3, 264, 20});
    vecs.push_back('{4, 1, 5, 5, 296, 8});

    clear_logs();
    #12;
    chk("rst_busy", int'(i1.busy), 0);
    chk("rst_done", int'(i1.done), 0);
    chk("rst_rd_en", int'(i1.rd_en), 0);
    chk("rst_win_valid", int'(i1.win_valid), 0);
    chk("rst_wr_en", int'(i1.wr_en), 0);
    chk("rst_rd_addr", int'(i1.rd_addr), 0);
    chk("rst_wr_addr", int'(i1.wr_addr), 0);
    chk("rst_wr_data", int'(i1.wr_data), 0);
    chk("rst_win_data_nonzero", int'(i1.win_data != 128'd0), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // 4x4 map: single window
    pulse(0);
    chk("u0_busy_after_start", int'(i0.busy), 1);
    wait_done(0, 200);
    chk("u0_busy_after_done", int'(i0.busy), 0);
    chk("u0_reads", nr[0], 16);
    for (int k = 0; k < 16; k++) chk($sformatf("u0_rd_addr[%0d]", k), rl[k], (k % 4) * 4 + k / 4);
    for (int e = 0; e < 16; e++) chk($sformatf("u0_win[%0d]", e), int'(win0[e*8 +: 8]), e);
    chk("u0_writes", nw[0], 1);
    apply_vecs(0);

    // 6x5 map with start pulses during FETCH and WAIT
    clear_logs();
    pulse(1);
    repeat (3) @(posedge clk);
    #1;
    pulse(1);
    while (nv[1] == 0 && cyc < 5000) @(posedge clk);
    #1;
    pulse(1);
    wait_done(1, 500);
    repeat (40) @(posedge clk);
    #1;
    chk("u1_writes", nw[1], 6);
    chk("u1_done_count", nd[1], 1);
    chk("u1_reads", nr[1], 48);
    apply_vecs(1);

    // MAC latency 3
    clear_logs();
    pulse(2);
    wait_done(2, 500);
    chk("u2_writes", nw[2], 6);
    apply_vecs(2);

    // All pixels -1, clamped result
    clear_logs();
    neg = 1'b1;
    pulse(1);
    wait_done(1, 500);
    chk("neg_writes", nw[1], 6);
    apply_vecs(3);
    neg = 1'b0;

    // Reset during WAIT of the second window
    clear_logs();
    pulse(1);
    while (nv[1] < 2 && cyc < 8000) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(i1.busy), 0);
    chk("mid_rst_rd_en", int'(i1.rd_en), 0);
    chk("mid_rst_wr_en", int'(i1.wr_en), 0);
    chk("mid_rst_win_valid", int'(i1.win_valid), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rd_before = nr[1];
    repeat (30) @(posedge clk);
    #1;
    chk("mid_rst_writes", nw[1], 1);
    chk("mid_rst_done", nd[1], 0);
    chk("mid_rst_no_reads", nr[1], rd_before);
    clear_logs();
    pulse(1);
    wait_done(1, 500);
    chk("restart_writes", nw[1], 6);
    for (int k = 0; k < 6; k++) chk($sformatf("restart_addr[%0d]", k), wa[1][k], k);
    apply_vecs(4);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
